// File: rtl/mult_seq_shift_add.sv
// Sequential shift-and-add unsigned multiplier.
// One operand pair is taken over a valid/ready handshake, one multiplier bit
// is folded into the accumulator per cycle, and the full-width product is
// offered downstream over a second valid/ready handshake.
module mult_seq_shift_add #(
  parameter int MW = 3,
  parameter int QW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MW-1:0]    m_in,
  input  logic [QW-1:0]    q_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MW+QW-1:0] product,
  output logic             busy
);

  localparam int PW = MW + QW;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [MW-1:0]   m_reg;
  logic [QW-1:0]   q_reg;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   row;
  logic [PW-1:0]   acc_sum;

  // Partial-product row for the current multiplier bit, placed at weight 2^cnt.
  always_comb begin
    row     = {{QW{1'b0}}, m_reg & {MW{q_reg[cnt]}}} << cnt;
    acc_sum = acc + row;
  end

  // Control FSM; every output is registered so in_ready depends on state only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      m_reg     <= '0;
      q_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg    <= m_in;
            q_reg    <= q_in;
            acc      <= '0;
            cnt      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_sum;
          if (cnt == CNT_LAST) begin
            // Hold cnt on the last bit so it never passes QW-1.
            state     <= DONE;
            out_valid <= 1'b1;
            product   <= acc_sum;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            product   <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          product   <= '0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_shift_add.sv
// Scoreboard bench for mult_seq_shift_add (MW=3, QW=2).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mult_seq_shift_add;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] m_in = '0;
  logic [1:0] q_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] product;
  logic       busy;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_recv = 0;
  int         n_sent = 0;
  int         ready_mode = 0;   // 0: always ready, 1: hold off, 2: random stalls
  bit         drop_pending = 1'b0;
  logic [4:0] sb[$];

  mult_seq_shift_add #(.MW(3), .QW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m_in      (m_in),
    .q_in      (q_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Downstream side: choose out_ready, then score any handshake that the next edge takes.
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (drop_pending) begin
      check("drop_out_valid", out_valid, 0);
      check("drop_product", product, 0);
      check("drop_in_ready", in_ready, 1);
      check("drop_busy", busy, 0);
      drop_pending = 1'b0;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", out_valid, 0);
      end else begin
        logic [4:0] exp_p;
        exp_p = sb.pop_front();
        check("product", product, exp_p);
        $display("OUT product=%0d expected=%0d", product, exp_p);
        n_recv++;
      end
      drop_pending = 1'b1;
    end
  end

  task automatic send(input logic [2:0] m, input logic [1:0] q);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    m_in     = m;
    q_in     = q;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", in_ready, 1);
    end else begin
      sb.push_back(5'(int'(m) * int'(q)));
      n_sent++;
      $display("IN  m=%0d q=%0d", m, q);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Basic op with latency checks
    ready_mode = 0;
    send(3'd5, 2'd3);
    check("calc_out_valid", out_valid, 0);
    check("calc_busy", busy, 1);
    check("calc_in_ready", in_ready, 0);
    @(negedge clk);
    check("lat_out_valid_e1", out_valid, 0);
    @(negedge clk);
    check("lat_out_valid_e2", out_valid, 1);
    drain();

    // Max and zero operands
    send(3'd7, 2'd3);
    send(3'd0, 2'd3);
    send(3'd7, 2'd0);
    drain();

    // Output held while downstream stalls
    ready_mode = 1;
    send(3'd6, 2'd2);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_product", product, 12);
      @(negedge clk);
    end
    ready_mode = 0;
    drain();

    // in_valid held high: second pair only taken after IDLE returns
    @(negedge clk);
    in_valid = 1'b1;
    m_in     = 3'd1;
    q_in     = 2'd1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    sb.push_back(5'd1);
    n_sent++;
    $display("IN  m=1 q=1 (held)");
    @(negedge clk);
    m_in = 3'd3;
    n = 0;
    while (n < 10) begin
      n++;
      if (in_ready) break;
      @(negedge clk);
    end
    check("held_gap_cycles", n, 4);
    check("held_in_ready", in_ready, 1);
    sb.push_back(5'd3);
    n_sent++;
    $display("IN  m=3 q=1 (held)");
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Reset in the first CALC cycle discards the op
    send(3'd5, 2'd3);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_product", product, 0);
    void'(sb.pop_back());
    n_sent--;
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd4, 2'd2);
    drain();

    // Exhaustive sweep with random stalls
    ready_mode = 2;
    for (int m = 0; m < 8; m++) begin
      for (int q = 0; q < 4; q++) begin
        send(3'(m), 2'(q));
      end
    end
    drain();
    ready_mode = 0;
    repeat (2) @(negedge clk);
    check("recv_count", n_recv, n_sent);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
